// File: rtl/simd2x_round_pkg.sv
// rtl/simd2x_round_pkg.sv - shared FSM type, LFSR constants and golden rounding helper
package simd2x_round_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SBRST,
    DIRECT,
    RANDOM,
    DRAIN,
    DONE
  } state_t;

  localparam int DIRECT_COUNT = 8;

  // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

  // Round half up then saturate; the extra top bit keeps x + H from wrapping
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                   input int rsh, input int ow);
    logic signed [64:0] t;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    t  = ($signed({x[63], x}) + (65'sd1 <<< (rsh - 1))) >>> rsh;
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    return t[63:0];
  endfunction

endpackage

// File: rtl/simd2x_round_delay.sv
// rtl/simd2x_round_delay.sv - parametric valid+data shift line with asynchronous clear
module simd2x_round_delay
  import simd2x_round_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_tvalid,
  input  logic [W-1:0] in_tdata,
  output logic         out_tvalid,
  output logic [W-1:0] out_tdata
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_tvalid = in_tvalid;
      assign out_tdata  = in_tdata;
    end else begin : g_line
      logic [DEPTH-1:0] vld_q;
      logic [DEPTH-1:0] vld_d;
      logic [W-1:0]     dat_q [DEPTH];
      logic [W-1:0]     dat_d [DEPTH];

      always_comb begin
        vld_d[0] = in_tvalid;
        dat_d[0] = in_tdata;
        for (int i = 1; i < DEPTH; i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          vld_q <= '0;
          dat_q <= '{default: '0};
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign out_tvalid = vld_q[DEPTH-1];
      assign out_tdata  = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/simd2x_round_stim.sv
// rtl/simd2x_round_stim.sv - stimulus sequencer and golden reference for the SIMD 2x rounding harness
module simd2x_round_stim
  import simd2x_round_pkg::*;
#(
  parameter int          INPUT_WIDTH  = 48,
  parameter int          RSHIFT_RANGE = 8,
  parameter int          OUTPUT_WIDTH = 9,
  parameter int          DUV_LATENCY  = 2,
  parameter logic [63:0] LFSR_SEED    = 64'h1
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           start,
  input  logic                           hold,
  input  logic [31:0]                    test_len,
  output logic signed [INPUT_WIDTH-1:0]  rin_ch0,
  output logic signed [INPUT_WIDTH-1:0]  rin_ch1,
  output logic                           rin_valid,
  output logic signed [INPUT_WIDTH-1:0]  rin_ch0_ref,
  output logic signed [INPUT_WIDTH-1:0]  rin_ch1_ref,
  output logic signed [OUTPUT_WIDTH-1:0] rout_ch0_ref,
  output logic signed [OUTPUT_WIDTH-1:0] rout_ch1_ref,
  output logic                           scoreboard_en,
  output logic                           scoreboard_reset,
  output logic                           busy,
  output logic                           done
);

  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int R  = RSHIFT_RANGE;

  function automatic logic signed [IW-1:0] direct_val(input logic [2:0] k);
    logic signed [63:0] h;
    logic signed [63:0] v;
    h = 64'sd1 <<< (R - 1);
    case (k)
      3'd1:    v = h;
      3'd2:    v = -h;
      3'd3:    v = h - 64'sd1;
      3'd4:    v = -h - 64'sd1;
      3'd7:    v = ((64'sd1 <<< (OW - 1)) - 64'sd1) * (64'sd1 <<< R) + h - 64'sd1;
      default: v = 64'sd0;
    endcase
    direct_val = IW'(v);
    if (k == 3'd5) direct_val = {1'b0, {(IW-1){1'b1}}};
    if (k == 3'd6) direct_val = {1'b1, {(IW-1){1'b0}}};
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          drain_q, drain_d;
  logic [63:0]          lfsr_q, lfsr_d;
  logic [63:0]          lfsr_mid;
  logic signed [IW-1:0] rin_ch0_q, rin_ch0_d;
  logic signed [IW-1:0] rin_ch1_q, rin_ch1_d;
  logic                 rin_valid_q, rin_valid_d;
  logic                 sbrst_q, sbrst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 dly_valid;
  logic [2*IW-1:0]      dly_data;
  logic signed [IW-1:0] dly_ch0, dly_ch1;
  logic                 sben_q, sben_d;
  logic signed [IW-1:0] ref0_q, ref0_d, ref1_q, ref1_d;
  logic signed [OW-1:0] rout0_q, rout0_d, rout1_q, rout1_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    drain_d     = drain_q;
    lfsr_d      = lfsr_q;
    rin_ch0_d   = rin_ch0_q;
    rin_ch1_d   = rin_ch1_q;
    rin_valid_d = 1'b0;
    sbrst_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    lfsr_mid    = lfsr_step(lfsr_q);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SBRST;
          sbrst_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          rem_d   = test_len;
          idx_d   = 3'd0;
          drain_d = 32'd0;
        end
      end
      SBRST: state_d = DIRECT;
      DIRECT: begin
        if (!hold) begin
          rin_valid_d = 1'b1;
          rin_ch0_d   = direct_val(idx_q);
          rin_ch1_d   = direct_val(3'd7 - idx_q);
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'(DIRECT_COUNT - 1)) begin
            state_d = (rem_q != 32'd0) ? RANDOM : DRAIN;
          end
        end
      end
      RANDOM: begin
        // Two LFSR steps per vector: ch0 from the current state, ch1 from the next
        if (!hold) begin
          rin_valid_d = 1'b1;
          rin_ch0_d   = lfsr_q[IW-1:0];
          rin_ch1_d   = lfsr_mid[IW-1:0];
          lfsr_d      = lfsr_step(lfsr_mid);
          rem_d       = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 32'(DUV_LATENCY - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  simd2x_round_delay #(
    .W     (2 * IW),
    .DEPTH (DUV_LATENCY - 1)
  ) u_delay (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_tvalid  (rin_valid_q),
    .in_tdata   ({rin_ch0_q, rin_ch1_q}),
    .out_tvalid (dly_valid),
    .out_tdata  (dly_data)
  );

  // Final alignment stage registers the golden values computed from the delayed inputs
  always_comb begin
    dly_ch0 = dly_data[2*IW-1:IW];
    dly_ch1 = dly_data[IW-1:0];
    sben_d  = dly_valid;
    ref0_d  = dly_ch0;
    ref1_d  = dly_ch1;
    rout0_d = OW'(round_sat(64'(dly_ch0), R, OW));
    rout1_d = OW'(round_sat(64'(dly_ch1), R, OW));
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      rem_q       <= 32'd0;
      drain_q     <= 32'd0;
      lfsr_q      <= LFSR_SEED;
      rin_ch0_q   <= '0;
      rin_ch1_q   <= '0;
      rin_valid_q <= 1'b0;
      sbrst_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sben_q      <= 1'b0;
      ref0_q      <= '0;
      ref1_q      <= '0;
      rout0_q     <= '0;
      rout1_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      drain_q     <= drain_d;
      lfsr_q      <= lfsr_d;
      rin_ch0_q   <= rin_ch0_d;
      rin_ch1_q   <= rin_ch1_d;
      rin_valid_q <= rin_valid_d;
      sbrst_q     <= sbrst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sben_q      <= sben_d;
      ref0_q      <= ref0_d;
      ref1_q      <= ref1_d;
      rout0_q     <= rout0_d;
      rout1_q     <= rout1_d;
    end
  end

  assign rin_ch0          = rin_ch0_q;
  assign rin_ch1          = rin_ch1_q;
  assign rin_valid        = rin_valid_q;
  assign rin_ch0_ref      = ref0_q;
  assign rin_ch1_ref      = ref1_q;
  assign rout_ch0_ref     = rout0_q;
  assign rout_ch1_ref     = rout1_q;
  assign scoreboard_en    = sben_q;
  assign scoreboard_reset = sbrst_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_simd2x_round_stim.sv
// tb/tb_simd2x_round_stim.sv - self-checking bench for simd2x_round_stim
module tb_simd2x_round_stim;

  localparam int          IW   = 48;
  localparam int          R    = 8;
  localparam int          OW   = 9;
  localparam int          LAT  = 2;
  localparam logic [63:0] SEED = 64'h1;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 start = 1'b0;
  logic                 hold = 1'b0;
  logic [31:0]          test_len = 32'd0;
  logic signed [IW-1:0] rin_ch0, rin_ch1, rin_ch0_ref, rin_ch1_ref;
  logic signed [OW-1:0] rout_ch0_ref, rout_ch1_ref;
  logic                 rin_valid, scoreboard_en, scoreboard_reset, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simd2x_round_stim #(
    .INPUT_WIDTH  (IW),
    .RSHIFT_RANGE (R),
    .OUTPUT_WIDTH (OW),
    .DUV_LATENCY  (LAT),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .start            (start),
    .hold             (hold),
    .test_len         (test_len),
    .rin_ch0          (rin_ch0),
    .rin_ch1          (rin_ch1),
    .rin_valid        (rin_valid),
    .rin_ch0_ref      (rin_ch0_ref),
    .rin_ch1_ref      (rin_ch1_ref),
    .rout_ch0_ref     (rout_ch0_ref),
    .rout_ch1_ref     (rout_ch1_ref),
    .scoreboard_en    (scoreboard_en),
    .scoreboard_reset (scoreboard_reset),
    .busy             (busy),
    .done             (done)
  );

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint direct_val(int k);
    longint h;
    h = longint'(1) << (R - 1);
    case (k)
      0:       return 0;
      1:       return h;
      2:       return -h;
      3:       return h - 1;
      4:       return -h - 1;
      5:       return (longint'(1) << (IW - 1)) - 1;
      6:       return -(longint'(1) << (IW - 1));
      default: return ((longint'(1) << (OW - 1)) - 1) * (longint'(1) << R) + h - 1;
    endcase
  endfunction

  function automatic longint golden(longint x);
    longint t, hi, lo;
    t  = (x + (longint'(1) << (R - 1))) >>> R;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    return (t > hi) ? hi : ((t < lo) ? lo : t);
  endfunction

  function automatic logic [63:0] lfsr_next(logic [63:0] s);
    int          taps [4] = '{64, 63, 61, 60};
    logic [63:0] mask = 64'h0;
    foreach (taps[i]) mask[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic longint low_iw(logic [63:0] s);
    logic signed [IW-1:0] v;
    v = s[IW-1:0];
    return v;
  endfunction

  typedef struct {
    longint c0;
    longint c1;
    int     cyc;
  } iss_t;

  typedef struct {
    longint in0;
    longint in1;
    longint exp0;
    longint exp1;
  } vec_t;

  iss_t        issq [$];
  logic [63:0] m_lfsr = SEED;
  int          m_dir = 0;
  int          cyc = 0;
  int          vcount = 0;
  int          encount = 0;
  int          sbrst_cnt = 0;
  int          last_valid_cyc = 0;
  int          done_cyc = 0;
  bit          done_prev = 1'b0;
  longint      got0 [8];
  longint      got1 [8];
  longint      gref0 [8];
  longint      gref1 [8];

  always @(negedge clk) begin
    iss_t e;
    if (!aresetn) begin
      issq.delete();
      m_lfsr    = SEED;
      m_dir     = 0;
      done_prev = 1'b0;
    end else begin
      cyc++;
      if (scoreboard_reset) begin
        sbrst_cnt++;
        m_dir = 0;
        check("sbrst_en_low", scoreboard_en, 0);
      end
      if (rin_valid) begin
        if (m_dir < 8) begin
          e.c0 = direct_val(m_dir);
          e.c1 = direct_val(7 - m_dir);
          m_dir++;
        end else begin
          e.c0   = low_iw(m_lfsr);
          m_lfsr = lfsr_next(m_lfsr);
          e.c1   = low_iw(m_lfsr);
          m_lfsr = lfsr_next(m_lfsr);
        end
        e.cyc = cyc;
        check("rin_ch0", rin_ch0, e.c0);
        check("rin_ch1", rin_ch1, e.c1);
        issq.push_back(e);
        vcount++;
        last_valid_cyc = cyc;
      end
      if (scoreboard_en) begin
        if (issq.size() == 0) begin
          check("sb_en_without_issue", scoreboard_en, 0);
        end else begin
          e = issq.pop_front();
          check("ref_ch0", rin_ch0_ref, e.c0);
          check("ref_ch1", rin_ch1_ref, e.c1);
          check("rout_ch0", rout_ch0_ref, golden(e.c0));
          check("rout_ch1", rout_ch1_ref, golden(e.c1));
          check("latency", cyc - e.cyc, LAT);
        end
        if (encount < 8) begin
          got0[encount]  = rout_ch0_ref;
          got1[encount]  = rout_ch1_ref;
          gref0[encount] = rin_ch0_ref;
          gref1[encount] = rin_ch1_ref;
        end
        encount++;
      end
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_rin_ch0"}, rin_ch0, 0);
    check({tag, "_rin_ch1"}, rin_ch1, 0);
    check({tag, "_rin_valid"}, rin_valid, 0);
    check({tag, "_ref0"}, rin_ch0_ref, 0);
    check({tag, "_ref1"}, rin_ch1_ref, 0);
    check({tag, "_rout0"}, rout_ch0_ref, 0);
    check({tag, "_rout1"}, rout_ch1_ref, 0);
    check({tag, "_sb_en"}, scoreboard_en, 0);
    check({tag, "_sb_rst"}, scoreboard_reset, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode 0: plain, 1: random hold, 2: 3-cycle hold mid-RANDOM, 3: start pulse mid-RANDOM
  task automatic do_run(input int len, input int mode);
    int     budget;
    bit     trig;
    int     hold_left;
    longint saved;
    budget    = 100 + 4 * len;
    trig      = 1'b0;
    hold_left = 0;
    saved     = 0;
    vcount    = 0;
    encount   = 0;
    sbrst_cnt = 0;
    done_cyc  = 0;
    test_len  = len;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_done_low", done, 0);
    check("start_busy", busy, 1);
    check("start_sbrst", scoreboard_reset, 1);
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (hold_left > 0) begin
        check("hold_valid_low", rin_valid, 0);
        check("hold_ch0_const", rin_ch0, saved);
        hold_left--;
        if (hold_left == 0) hold = 1'b0;
      end else if (mode == 1) begin
        hold = ($urandom_range(0, 3) == 0);
      end else if (mode == 2 && !trig && vcount >= 10) begin
        trig      = 1'b1;
        saved     = rin_ch0;
        hold      = 1'b1;
        hold_left = 3;
      end else if (mode == 3 && !trig && vcount >= 10) begin
        trig  = 1'b1;
        start = 1'b1;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    check("run_done", done, 1);
    check("run_busy_low", busy, 0);
    check("run_valid_count", vcount, 8 + len);
    check("run_en_count", encount, 8 + len);
    check("run_sbrst_count", sbrst_cnt, 1);
    check("done_after_last_valid", done_cyc - last_valid_cyc, 2);
  endtask

  vec_t   tab [8];
  longint exp0_list [8] = '{0, 1, 0, 0, -1, 255, -256, 255};
  longint exp1_list [8] = '{255, -256, 255, -1, 0, 0, 1, 0};

  initial begin
    for (int i = 0; i < 8; i++) begin
      tab[i].in0  = direct_val(i);
      tab[i].in1  = direct_val(7 - i);
      tab[i].exp0 = exp0_list[i];
      tab[i].exp1 = exp1_list[i];
    end

    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    do_run(0, 0);
    for (int i = 0; i < 8; i++) begin
      check("dir_rout0", got0[i], tab[i].exp0);
      check("dir_rout1", got1[i], tab[i].exp1);
      check("dir_ref0", gref0[i], tab[i].in0);
      check("dir_ref1", gref1[i], tab[i].in1);
    end

    do_run(5, 2);
    do_run(4, 3);
    do_run($urandom_range(10, 30), 1);

    vcount   = 0;
    test_len = 32'd20;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 200 && vcount < 12; c++) begin
      @(posedge clk); #1;
    end
    check("midrst_progress", vcount, 12);
    aresetn = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1 aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_sb_en", scoreboard_en, 0);
      check("post_rst_valid", rin_valid, 0);
    end

    do_run(3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
